// File: rtl/gold_nic_pkg.sv
// Shared constants for the gold NIC: register map, status bit positions and field widths.
package gold_nic_pkg;

  typedef enum logic [1:0] {
    ADDR_OUT_BUF  = 2'd0,
    ADDR_OUT_STAT = 2'd1,
    ADDR_IN_BUF   = 2'd2,
    ADDR_IN_STAT  = 2'd3
  } nic_addr_e;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DROP_W = 8;

  // Status bit positions use the MSB-first numbering of the data word (bit 0 = MSB).
  localparam int unsigned ST_VC0_FULL  = 0;
  localparam int unsigned ST_VC1_FULL  = 1;
  localparam int unsigned ST_WR_ERR    = 2;
  localparam int unsigned ST_IN_NEMPTY = 0;
  localparam int unsigned ST_IN_FULL   = 1;

  // Count fields sit at the LSB end; each offset is the distance back from DATA_W.
  localparam int unsigned VC0_CNT_OFS = 4;
  localparam int unsigned VC1_CNT_OFS = 8;
  localparam int unsigned IN_CNT_OFS  = 4;
  localparam int unsigned DROP_OFS    = 16;

endpackage

// File: rtl/nic_sync_fifo.sv
// Small synchronous FIFO with register-array storage, occupancy count and async active-low reset.
module nic_sync_fifo
  import gold_nic_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // Full/empty are pre-edge, so a push into a full FIFO is lost even if it pops this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gold_nic_vc.sv
// Gold NIC with two outbound virtual-channel FIFOs and one inbound FIFO with a saturating drop counter.
module gold_nic_vc
  import gold_nic_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned VC_BIT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicEnWr,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  logic [1:0]        vc_push;
  logic [1:0]        vc_pop;
  logic [1:0]        vc_full;
  logic [1:0]        vc_empty;
  logic [DATA_W-1:0] vc_head  [2];
  logic [CNT_W-1:0]  vc_count [2];

  logic [DATA_W-1:0] in_head;
  logic [CNT_W-1:0]  in_count;
  logic              in_full;
  logic              in_empty;
  logic              in_pop;
  logic              drop_ev;

  logic              wr_buf;
  logic              rd_en;
  logic              sel;
  logic              launch;
  logic              wr_err;
  logic [DROP_W-1:0] drop_cnt;
  logic [0:DATA_W-1] rd_data;

  for (genvar v = 0; v < 2; v++) begin : g_vc
    nic_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (vc_push[v]),
      .pop   (vc_pop[v]),
      .din   (d_in),
      .head  (vc_head[v]),
      .count (vc_count[v]),
      .full  (vc_full[v]),
      .empty (vc_empty[v])
    );
  end

  nic_sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (net_si),
    .pop   (in_pop),
    .din   (net_di),
    .head  (in_head),
    .count (in_count),
    .full  (in_full),
    .empty (in_empty)
  );

  assign net_ri = reset & ~in_full;

  always_comb begin
    wr_buf     = nicEn & nicEnWr & (addr == ADDR_OUT_BUF);
    rd_en      = nicEn & ~nicEnWr;
    vc_push[0] = wr_buf & ~d_in[VC_BIT];
    vc_push[1] = wr_buf & d_in[VC_BIT];
    // The VC launched at this edge is the one whose polarity phase follows it.
    sel        = ~net_polarity;
    launch     = net_ro & ~vc_empty[sel];
    vc_pop     = '0;
    vc_pop[sel] = launch;
    in_pop     = rd_en & (addr == ADDR_IN_BUF) & ~in_empty;
    drop_ev    = net_si & in_full;

    rd_data = '0;
    case (nic_addr_e'(addr))
      ADDR_OUT_STAT: begin
        rd_data[ST_VC0_FULL] = vc_full[0];
        rd_data[ST_VC1_FULL] = vc_full[1];
        rd_data[ST_WR_ERR]   = wr_err;
        rd_data[DATA_W-VC1_CNT_OFS +: CNT_W] = vc_count[1];
        rd_data[DATA_W-VC0_CNT_OFS +: CNT_W] = vc_count[0];
      end
      ADDR_IN_BUF: rd_data = in_empty ? '0 : in_head;
      ADDR_IN_STAT: begin
        rd_data[ST_IN_NEMPTY] = ~in_empty;
        rd_data[ST_IN_FULL]   = in_full;
        rd_data[DATA_W-DROP_OFS +: DROP_W]  = drop_cnt;
        rd_data[DATA_W-IN_CNT_OFS +: CNT_W] = in_count;
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_out    <= '0;
      net_so   <= 1'b0;
      net_do   <= '0;
      wr_err   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      d_out  <= rd_en ? rd_data : '0;
      net_so <= launch;
      net_do <= launch ? vc_head[sel] : '0;
      if (wr_buf && vc_full[d_in[VC_BIT]]) wr_err <= 1'b1;
      else if (rd_en && addr == ADDR_OUT_STAT) wr_err <= 1'b0;
      // A drop coinciding with the clearing read must still be counted.
      if (rd_en && addr == ADDR_IN_STAT) drop_cnt <= DROP_W'(drop_ev);
      else if (drop_ev && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_gold_nic_vc.sv
// Directed self-checking bench for gold_nic_vc with default parameters (64-bit words, depth 4).
module tb_gold_nic_vc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = '0;
  logic [0:63] d_in = '0;
  logic [0:63] d_out;
  logic        nicEn = 1'b0;
  logic        nicEnWr = 1'b0;
  logic        net_si = 1'b0;
  logic        net_ri;
  logic [0:63] net_di = '0;
  logic        net_so;
  logic        net_ro = 1'b0;
  logic [0:63] net_do;
  logic        net_polarity = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp0[$];
  logic [63:0] exp1[$];
  logic [63:0] rv;

  gold_nic_vc #(.DATA_W(64), .OUT_DEPTH(4), .IN_DEPTH(4), .VC_BIT(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicEnWr      (nicEnWr),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    net_polarity = ~net_polarity;
  endtask

  task automatic proc_write(input logic [63:0] v);
    nicEn = 1'b1; nicEnWr = 1'b1; addr = 2'd0; d_in = v;
    tick();
    nicEn = 1'b0; nicEnWr = 1'b0;
  endtask

  task automatic proc_read(input logic [1:0] a, output logic [63:0] v);
    nicEn = 1'b1; nicEnWr = 1'b0; addr = a;
    tick();
    v = d_out;
    nicEn = 1'b0;
  endtask

  task automatic push_in(input logic [63:0] v);
    net_si = 1'b1; net_di = v;
    tick();
    net_si = 1'b0;
  endtask

  // Collect n launches; each must appear in its VC's polarity phase and in per-VC order.
  task automatic drain(input int n);
    int got = 0;
    for (int c = 0; c < 40 && got < n; c++) begin
      tick();
      if (net_so) begin
        got++;
        check("launch_phase", {63'b0, net_polarity}, {63'b0, net_do[0]});
        if (net_do[0] && exp1.size() > 0) check("vc1_data", net_do, exp1.pop_front());
        else if (!net_do[0] && exp0.size() > 0) check("vc0_data", net_do, exp0.pop_front());
        else check("unexpected_pkt", net_do, 64'h0);
      end
    end
    check("drain_count", got, n);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_dout", d_out, 64'h0);
    check("rst_so", {63'b0, net_so}, 64'h0);
    check("rst_do", net_do, 64'h0);
    check("rst_ri", {63'b0, net_ri}, 64'h0);
    reset = 1'b1;
    #1;
    check("ri_after_rst", {63'b0, net_ri}, 64'h1);

    // Single write on vc0
    net_ro = 1'b1;
    proc_write(64'h1);
    check("wr_no_same_edge", {63'b0, net_so}, 64'h0);
    exp0.push_back(64'h1);
    drain(1);
    proc_read(2'd1, rv);
    check("single_stat", rv, 64'h0);

    // VC isolation: vc1 overfilled while vc0 still accepts
    net_ro = 1'b0;
    for (int i = 0; i < 4; i++) begin
      proc_write(64'h8000_0000_0000_0010 + 64'(i));
      exp1.push_back(64'h8000_0000_0000_0010 + 64'(i));
    end
    proc_write(64'h8000_0000_0000_0014);
    proc_write(64'h20);
    exp0.push_back(64'h20);
    proc_read(2'd1, rv);
    check("iso_stat", rv, 64'h6000_0000_0000_0041);
    proc_read(2'd1, rv);
    check("iso_stat_clr", rv, 64'h4000_0000_0000_0041);
    net_ro = 1'b1;
    drain(5);
    proc_read(2'd1, rv);
    check("iso_drained", rv, 64'h0);

    // Inbound read
    push_in(64'h5);
    proc_read(2'd3, rv);
    check("in_stat1", rv, 64'h8000_0000_0000_0001);
    proc_read(2'd2, rv);
    check("in_data", rv, 64'h5);
    proc_read(2'd3, rv);
    check("in_stat_empty", rv, 64'h0);
    proc_read(2'd2, rv);
    check("in_empty_read", rv, 64'h0);

    // Inbound overflow: 7 pushes into depth 4
    net_si = 1'b1;
    for (int i = 0; i < 7; i++) begin
      net_di = 64'h100 + 64'(i);
      tick();
      if (i < 4) check("ovf_ri", {63'b0, net_ri}, {63'b0, (i < 3)});
    end
    net_si = 1'b0;
    check("ovf_ri_end", {63'b0, net_ri}, 64'h0);
    proc_read(2'd3, rv);
    check("ovf_stat", rv, 64'hC000_0000_0000_0304);
    proc_read(2'd3, rv);
    check("ovf_stat_clr", rv, 64'hC000_0000_0000_0004);
    for (int i = 0; i < 4; i++) begin
      proc_read(2'd2, rv);
      check("ovf_data", rv, 64'h100 + 64'(i));
    end
    check("ovf_ri_back", {63'b0, net_ri}, 64'h1);

    // Simultaneous inbound push and pop
    push_in(64'h55);
    net_si = 1'b1; net_di = 64'h66;
    proc_read(2'd2, rv);
    net_si = 1'b0;
    check("sim_in_pop", rv, 64'h55);
    proc_read(2'd3, rv);
    check("sim_in_stat", rv, 64'h8000_0000_0000_0001);
    proc_read(2'd2, rv);
    check("sim_in_data", rv, 64'h66);

    // Simultaneous vc0 write and vc0 launch
    net_ro = 1'b0;
    proc_write(64'h71);
    proc_write(64'h72);
    if (net_polarity == 1'b0) tick();
    net_ro = 1'b1;
    proc_write(64'h73);
    check("sim_out_so", {63'b0, net_so}, 64'h1);
    check("sim_out_do", net_do, 64'h71);
    net_ro = 1'b0;
    proc_read(2'd1, rv);
    check("sim_out_stat", rv, 64'h2);
    exp0.push_back(64'h72);
    exp0.push_back(64'h73);
    net_ro = 1'b1;
    drain(2);

    // Reset with FIFOs partly full
    net_ro = 1'b0;
    proc_write(64'h81);
    proc_write(64'h82);
    proc_write(64'h8000_0000_0000_0091);
    push_in(64'hA1);
    push_in(64'hA2);
    if (net_polarity == 1'b0) tick();
    net_ro = 1'b1;
    proc_read(2'd3, rv);
    check("pre_rst_so", {63'b0, net_so}, 64'h1);
    reset = 1'b0;
    #1;
    check("mid_rst_dout", d_out, 64'h0);
    check("mid_rst_so", {63'b0, net_so}, 64'h0);
    check("mid_rst_do", net_do, 64'h0);
    check("mid_rst_ri", {63'b0, net_ri}, 64'h0);
    net_ro = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    check("post_rst_ri", {63'b0, net_ri}, 64'h1);
    proc_read(2'd1, rv);
    check("post_rst_stat1", rv, 64'h0);
    proc_read(2'd3, rv);
    check("post_rst_stat3", rv, 64'h0);
    proc_read(2'd2, rv);
    check("post_rst_in", rv, 64'h0);
    net_ro = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (net_so) seen++;
      end
      check("post_rst_no_launch", seen, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gold_nic_vc.md
# gold_nic_vc

Parametrised successor to the single-slot gold NIC. It sits between one processor (memory-mapped, 2-bit address) and one mesh router port. Outbound traffic goes through two per-virtual-channel FIFOs, so a blocked VC never stalls the other one. Inbound traffic goes through one FIFO with a saturating drop counter.

## Interface
Parameters:
- DATA_W, 64, packet/word width; bits indexed [0:DATA_W-1], bit 0 = MSB
- OUT_DEPTH, 4, entries per outbound VC FIFO (2..15)
- IN_DEPTH, 4, entries in inbound FIFO (2..15)
- VC_BIT, 0, index of the VC bit in the packet header

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset; clears all state
- addr  in  2  processor register select: 0 out-buffer write, 1 out status, 2 in-buffer read, 3 in status
- d_in  in  DATA_W  processor write data
- d_out  out  DATA_W  registered processor read data
- nicEn  in  1  processor access enable
- nicEnWr  in  1  1 = write, 0 = read (qualified by nicEn)
- net_si  in  1  router sends packet to NIC
- net_ri  out  1  NIC can accept an inbound packet (= inbound FIFO not full; 0 while reset asserted)
- net_di  in  DATA_W  inbound packet
- net_so  out  1  NIC presents outbound packet (registered)
- net_ro  in  1  router can accept outbound packet
- net_do  out  DATA_W  outbound packet (registered)
- net_polarity  in  1  router VC phase; toggles every cycle

## Operation
- **Processor write, addr 0 (nicEn & nicEnWr):** d_in goes to VC FIFO d_in[VC_BIT]. If that FIFO is full at the edge, the word is dropped and sticky wr_err is set. Writes to addr 1/2/3 are ignored.
- **Processor read (nicEn & ~nicEnWr):** d_out is loaded at the edge. In every other cycle, d_out loads 0.
- **addr 1 read:**
  - d_out[0] = vc0 full, d_out[1] = vc1 full, d_out[2] = wr_err.
  - d_out[DATA_W-8:DATA_W-5] = vc1 count; d_out[DATA_W-4:DATA_W-1] = vc0 count; all other bits 0.
  - The read clears wr_err.
- **addr 2 read:** d_out = inbound head and the head is popped. If the FIFO is empty, d_out = 0 and there is no pop. There is no bypass: a push in the same cycle is not visible.
- **addr 3 read:**
  - d_out[0] = inbound non-empty, d_out[1] = inbound full.
  - d_out[DATA_W-16:DATA_W-9] = drop count; d_out[DATA_W-4:DATA_W-1] = inbound count.
  - The read clears the drop count; a drop in the same cycle leaves the count at 1.
- **Inbound:** on net_si & ~full, net_di is pushed. On net_si & full, the packet is discarded and the 8-bit drop count increments, saturating at 255. Pop and push in the same cycle are both legal. Full is evaluated on pre-edge state.
- **Outbound launch:**
  - At each edge, sel = ~net_polarity.
  - If net_ro and FIFO[sel] is non-empty: net_so <= 1, net_do <= head(sel), pop(sel).
  - Otherwise net_so <= 0 and net_do <= 0.
  - A launched packet is therefore presented in the cycle where net_polarity == its VC bit.
- **Push and launch pop on the same VC FIFO in one cycle:** both happen and the count is unchanged. Full is judged pre-edge.
- **Packets are forwarded unmodified;** the NIC does not alter hop count or direction bits.

## Timing
- **Reset (async assert):**
  - All FIFOs empty; counts, wr_err and drop count are 0.
  - d_out = 0, net_so = 0, net_do = 0, net_ri = 0.
  - After deassertion, net_ri = 1 combinationally.
- **Processor read latency:** 1 cycle. The read is sampled at edge N and d_out is valid from N until N+1.
- **Write to launch:** minimum 1 cycle. A write sampled at edge N is eligible at edge N+1 if net_ro and the polarity select match; otherwise it launches at N+2.
- **Inbound:** a packet accepted at edge N is readable by an addr 2 read sampled at edge N+1. net_ri falls in the cycle after the edge that fills the FIFO.
- **net_ro low:** both VC FIFOs hold. Order within each VC is FIFO; order across VCs is not guaranteed.
- **Reset asserted mid-transfer:** in-flight and buffered packets are lost; no partial state survives.

## Structure
- **gold_nic_pkg:**
  - Address constants (ADDR_OUT_BUF = 0, ADDR_OUT_STAT = 1, ADDR_IN_BUF = 2, ADDR_IN_STAT = 3).
  - Status bit/field positions.
  - Drop counter width (8).
- **nic_sync_fifo (sub-module):** parameters WIDTH, DEPTH. Push/pop, registered head, count, full and empty outputs, async active-low reset. Instantiated three times (vc0, vc1, inbound).
- **Top level:** decode, status muxing, launch select, counters.

## Test plan
- **Single write:** reset, net_ro=1, write addr 0 packet vc=0 payload 1 → net_so=1 with net_do payload 1 in the first cycle where net_polarity=0; addr 1 read then returns count 0.
- **VC isolation:**
  - Setup: net_ro=0, write vc1 ×OUT_DEPTH then one more vc1 and one vc0.
  - Expected while held: addr 1 shows bit1=1, wr_err=1, vc0 count 1.
  - Expected after net_ro=1: vc0 and the 4 vc1 packets drain in order, each aligned to its polarity.
- **Inbound read:** net_si with payload 5 → addr 3 shows non-empty, count 1; addr 2 read returns payload 5 next cycle; a following addr 3 read shows empty.
- **Inbound overflow:**
  - Setup: IN_DEPTH+3 consecutive net_si with no reads.
  - Expected: net_ri drops; addr 3 shows full and drop count 3; a second addr 3 read shows drop count 0.
- **Simultaneous traffic:** push inbound while the processor pops it, and write vc0 while vc0 launches, in the same cycle → counts unchanged, no data lost or duplicated.
- **Reset mid-operation:** reset asserted with all FIFOs partly full → all outputs 0 immediately; after release all status reads return empty, and net_ri=1.
